// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, instruction size and
// the fetch-PC controller state encoding.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_ERROR  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Branch target adder: ex_pc + ex_imm modulo 2^XLEN, plus an instruction
// alignment check on the result.
module pc_target_calc #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    always_comb begin
        target     = ex_pc + ex_imm;
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: steps sequentially, redirects on taken EX branches, flushes
// the younger pipeline stages and ignores branch inputs during a squash window.
module pc_redirect_unit #(
    parameter int              XLEN          = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int              SQUASH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            misalign_err,
    output logic [31:0]     branch_count,
    output logic [31:0]     taken_count
);

    import riscv_pkg::*;

    localparam int CW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

    pc_state_e       state;
    logic [CW-1:0]   sq_cnt;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            resolve;
    logic            take;
    logic            step;
    logic [XLEN-1:0] pc_seq;

    pc_target_calc #(.XLEN(XLEN)) u_target (
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .target     (target),
        .misaligned (misaligned)
    );

    // NOTE: flushes are driven combinationally so the wrong-path instructions
    // are squashed in the same cycle the EX stage resolves the branch.
    always_comb begin
        resolve     = ex_valid & ex_is_branch & (state == ST_RUN);
        take        = resolve & ex_taken;
        step        = ~stall & fetch_ready;
        pc_seq      = pc_out + XLEN'(INSN_BYTES);
        if_id_flush = take;
        id_ex_flush = take;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            sq_cnt       <= '0;
            pc_out       <= RESET_PC;
            pc_valid     <= 1'b1;
            misalign_err <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (resolve) begin
                        branch_count <= branch_count + 32'd1;
                    end
                    if (take) begin
                        taken_count <= taken_count + 32'd1;
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                            pc_valid     <= 1'b0;
                            state        <= ST_ERROR;
                        end else begin
                            // Redirect wins over stall and a busy imem.
                            pc_out <= target;
                            sq_cnt <= CW'(SQUASH_CYCLES - 1);
                            if (SQUASH_CYCLES > 1) begin
                                state <= ST_SQUASH;
                            end
                        end
                    end else if (step) begin
                        pc_out <= pc_seq;
                    end
                end
                ST_SQUASH: begin
                    if (step) begin
                        pc_out <= pc_seq;
                    end
                    if (sq_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        sq_cnt <= sq_cnt - CW'(1);
                    end
                end
                ST_ERROR: begin
                    pc_valid <= 1'b0;
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

endmodule
